// File: rtl/preg_freelist.sv
// Physical-register free list: circular FIFO of free preg ids with an in-use bitmap.
// After reset or squash a sequential walk refills the list with 0..PRFSIZE-1.
module preg_freelist #(
    parameter int PRFSIZE      = 32,
    parameter int PREG_ID_BITS = $clog2(PRFSIZE)
) (
    input  logic                    clk,
    input  logic                    rstn,
    output logic                    alloc_valid,
    input  logic                    alloc_ready,
    output logic [PREG_ID_BITS-1:0] alloc_preg,
    input  logic                    free_valid,
    input  logic [PREG_ID_BITS-1:0] free_preg,
    input  logic                    squash_valid,
    output logic [PREG_ID_BITS:0]   free_count,
    output logic                    busy,
    output logic                    err
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [PREG_ID_BITS:0]   CNT_FULL = (PREG_ID_BITS+1)'(PRFSIZE);
    localparam logic [PREG_ID_BITS:0]   CNT_ONE  = (PREG_ID_BITS+1)'(1);
    localparam logic [PREG_ID_BITS-1:0] ID_ONE   = PREG_ID_BITS'(1);
    localparam logic [PREG_ID_BITS-1:0] ID_LAST  = PREG_ID_BITS'(PRFSIZE - 1);

    logic [0:0]              state_q, state_d;
    logic [PREG_ID_BITS-1:0] head_q, head_d;
    logic [PREG_ID_BITS-1:0] tail_q, tail_d;
    logic [PREG_ID_BITS-1:0] idx_q, idx_d;
    logic [PREG_ID_BITS:0]   count_q, count_d;
    logic [PRFSIZE-1:0]      inuse_q, inuse_d;
    logic                    err_q, err_d;
    logic [PREG_ID_BITS-1:0] fl_q [PRFSIZE];
    logic [PREG_ID_BITS-1:0] fl_d [PRFSIZE];

    logic alloc_fire;
    logic free_legal;
    logic free_illegal;

    assign alloc_valid = (state_q == ST_RUN) && (count_q != '0);
    assign alloc_preg  = alloc_valid ? fl_q[head_q] : '0;
    assign free_count  = count_q;
    assign busy        = (state_q == ST_INIT);
    assign err         = err_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        idx_d   = idx_q;
        count_d = count_q;
        inuse_d = inuse_q;
        err_d   = err_q;
        fl_d    = fl_q;

        alloc_fire   = alloc_valid && alloc_ready;
        free_legal   = free_valid && inuse_q[free_preg] && (count_q < CNT_FULL);
        free_illegal = free_valid && !inuse_q[free_preg];

        if (!rstn || squash_valid) begin
            state_d = ST_INIT;
            head_d  = '0;
            tail_d  = '0;
            idx_d   = '0;
            count_d = '0;
            inuse_d = '0;
            err_d   = 1'b0;
        end else if (state_q == ST_INIT) begin
            fl_d[tail_q] = idx_q;
            tail_d       = tail_q + ID_ONE;
            idx_d        = idx_q + ID_ONE;
            count_d      = count_q + CNT_ONE;
            if (idx_q == ID_LAST) begin
                state_d = ST_RUN;
            end
        end else begin
            if (free_legal) begin
                fl_d[tail_q]       = free_preg;
                tail_d             = tail_q + ID_ONE;
                inuse_d[free_preg] = 1'b0;
            end
            if (free_illegal) begin
                err_d = 1'b1;
            end
            // Applied after the free clear so a same-id alloc keeps the bit set.
            if (alloc_fire) begin
                head_d                = head_q + ID_ONE;
                inuse_d[fl_q[head_q]] = 1'b1;
            end
            case ({alloc_fire, free_legal})
                2'b10:   count_d = count_q - CNT_ONE;
                2'b01:   count_d = count_q + CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
        idx_q   <= idx_d;
        count_q <= count_d;
        inuse_q <= inuse_d;
        err_q   <= err_d;
        fl_q    <= fl_d;
    end

endmodule

// File: tb/tb_preg_freelist.sv
// Bench for preg_freelist (PRFSIZE=8): directed scenarios plus random traffic,
// every cycle compared against a queue-based model of the free list.
module tb_preg_freelist;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rstn;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [W-1:0] alloc_preg;
    logic         free_valid;
    logic [W-1:0] free_preg;
    logic         squash_valid;
    logic [W:0]   free_count;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    preg_freelist #(.PRFSIZE(N)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_preg  (alloc_preg),
        .free_valid  (free_valid),
        .free_preg   (free_preg),
        .squash_valid(squash_valid),
        .free_count  (free_count),
        .busy        (busy),
        .err         (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: list contents as a queue, ownership as a bit per id.
    int q[$];
    bit inuse_m[N];
    bit err_m    = 1'b0;
    bit busy_m   = 1'b1;
    int init_idx = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_inuse();
        int ids[$];
        for (int i = 0; i < N; i++) if (inuse_m[i]) ids.push_back(i);
        if (ids.size() == 0) return -1;
        return ids[$urandom_range(ids.size() - 1)];
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) inuse_m[i] = 1'b0;
        err_m    = 1'b0;
        busy_m   = 1'b1;
        init_idx = 0;
    endtask

    // One clock: check outputs mid-cycle, drive inputs, then advance model at the edge.
    task automatic cyc(input bit r, input bit ar, input bit fv, input int fp, input bit sq);
        bit av;
        bit fire;
        bit legal;
        int pid;
        @(negedge clk);
        av = !busy_m && (q.size() != 0);
        chk("busy", int'(busy), int'(busy_m));
        chk("alloc_valid", int'(alloc_valid), int'(av));
        chk("alloc_preg", int'(alloc_preg), av ? q[0] : 0);
        chk("free_count", int'(free_count), q.size());
        chk("err", int'(err), int'(err_m));
        rstn         = r;
        alloc_ready  = ar;
        free_valid   = fv;
        free_preg    = W'(fp);
        squash_valid = sq;
        @(posedge clk);
        if (!r || sq) begin
            model_reset();
        end else if (busy_m) begin
            q.push_back(init_idx);
            init_idx++;
            if (init_idx == N) busy_m = 1'b0;
        end else begin
            fire  = av && ar;
            pid   = fire ? q[0] : -1;
            legal = fv && inuse_m[fp] && (q.size() < N);
            if (fv && !inuse_m[fp]) err_m = 1'b1;
            if (fire) void'(q.pop_front());
            if (legal) begin
                q.push_back(fp);
                inuse_m[fp] = 1'b0;
            end
            if (fire) inuse_m[pid] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        int fp;
        rstn         = 1'b0;
        alloc_ready  = 1'b0;
        free_valid   = 1'b0;
        free_preg    = '0;
        squash_valid = 1'b0;
        model_reset();

        // Reset release and INIT walk, then drain past empty.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        idle(8);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0);

        // Out-of-order refill from empty; free at count 0 must not bypass.
        cyc(1, 1, 1, 5, 0);
        cyc(1, 0, 1, 2, 0);
        cyc(1, 0, 1, 7, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);

        // Steady state at count 4 with simultaneous alloc and free.
        cyc(1, 0, 0, 0, 1);
        idle(8);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, pick_inuse(), 0);
        idle(1);

        // Double free of id 3 and sticky err.
        cyc(1, 0, 0, 0, 1);
        idle(8);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 3, 0);
        cyc(1, 0, 1, 3, 0);
        idle(3);

        // Squash at count 2 with alloc and free pending, then a squash mid-INIT.
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, pick_inuse(), 1);
        idle(4);
        cyc(1, 0, 0, 0, 1);
        idle(10);

        // Randomized traffic with occasional squash/reset and illegal frees.
        for (int i = 0; i < 3000; i++) begin
            fp = pick_inuse();
            if (fp < 0 || $urandom_range(9) == 0) fp = $urandom_range(N - 1);
            cyc(($urandom_range(299) != 0),
                ($urandom_range(2) != 0),
                ($urandom_range(1) == 0),
                fp,
                ($urandom_range(149) == 0));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/preg_freelist.md
# preg_freelist

Physical-register free-list manager for the rename stage. It replaces the counter-based allocator with a circular FIFO of free physical register ids, so pregs can be released out of allocation order. Rename pops one preg per renamed destination, and commit pushes back the preg of each retired `needprf2arf` entry. After reset or squash, the block rebuilds the full list with a sequential INIT walk, and it flags illegal releases.

## Interface
Parameters:
- PRFSIZE, default 32: number of physical registers; must be a power of two, ≥ 4.
- PREG_ID_BITS, default $clog2(PRFSIZE): preg id width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- alloc_valid  out  1  a free preg is available on alloc_preg.
- alloc_ready  in  1  rename consumes alloc_preg this cycle.
- alloc_preg  out  PREG_ID_BITS  preg id at the list head; 0 when alloc_valid=0.
- free_valid  in  1  commit returns a preg.
- free_preg  in  PREG_ID_BITS  preg id being returned.
- squash_valid  in  1  pipeline flush; all pregs become free.
- free_count  out  PREG_ID_BITS+1  number of ids currently in the list (0..PRFSIZE).
- busy  out  1  INIT walk in progress.
- err  out  1  sticky illegal-release flag; cleared only by reset or squash.

## Operation
Storage and state:
- fl[PRFSIZE] holds preg ids.
- head is the read pointer and tail is the write pointer; both are PREG_ID_BITS wide and wrap naturally.
- count is PREG_ID_BITS+1 wide.
- inuse[PRFSIZE] is a bitmap with one bit set per allocated preg.
- FSM states: INIT and RUN.

INIT:
- Entry (rstn=0 or squash_valid=1, from any state): head=0, tail=0, count=0, idx=0, inuse=0, err=0, state=INIT.
- Each INIT cycle: fl[tail]<=idx, then tail++, idx++, count++.
- After the write with idx=PRFSIZE-1: state<=RUN. At that point count=PRFSIZE and tail has wrapped to 0.
- alloc_valid=0 throughout INIT. free_valid is ignored (dropped, not flagged).

RUN:
- alloc_valid = (count != 0).
- Allocation fires on alloc_valid && alloc_ready: head++, count--, inuse[fl[head]]<=1.
- A legal free is free_valid && inuse[free_preg] && count<PRFSIZE. It does fl[tail]<=free_preg, tail++, count++, inuse[free_preg]<=0.
- An illegal free is free_valid with inuse[free_preg]=0, i.e. a double free or a never-allocated id. It sets err<=1, the list is unchanged, and the id is dropped.
- Simultaneous legal alloc and free: both pointers advance and count is unchanged.
- Free of the same id being allocated in the same cycle: the alloc-side inuse set wins and err<=1. This case is illegal upstream.
- No bypass: with count=0, a same-cycle free does not make alloc_valid rise until the next cycle.
- count never exceeds PRFSIZE and never underflows. alloc_ready while alloc_valid=0 has no effect.

Precedence: rstn=0 beats squash_valid, which beats alloc/free. squash_valid during INIT restarts the walk from idx=0.

Outputs: free_count=count; busy=(state==INIT); alloc_preg=alloc_valid ? fl[head] : 0.

## Timing
- Reset values: alloc_valid=0, alloc_preg=0, free_count=0, busy=1, err=0.
- INIT takes exactly PRFSIZE cycles. The first rising edge with rstn=1 (or squash_valid=0) writes fl[0]. alloc_valid=1 and busy=0 appear after the PRFSIZE-th such edge.
- alloc_valid and alloc_preg are combinational from registered state only; there is no combinational path from alloc_ready or free_valid to any output.
- Pop and push take effect at the clock edge; the new head is visible the following cycle.
- err is registered and sets on the edge after the illegal free.
- Allocation order after INIT is 0,1,...,PRFSIZE-1. Thereafter ids return in free order (FIFO).

## Test plan
All scenarios use PRFSIZE=8.
- Reset release: hold rstn=0 for 2 cycles, then release -> busy=1 and free_count counts 1..8 over 8 edges. Then alloc_valid=1, alloc_preg=0, busy=0.
- Drain: alloc_ready=1 continuously -> alloc_preg takes 0..7 on consecutive cycles, alloc_valid=0 after the 8th pop, free_count=0. Further alloc_ready has no effect.
- Out-of-order refill: from empty, free 5, then 2, then 7 -> free_count=3 and the next allocs return 5, 2, 7 in order. The free of 5 at count=0 gives alloc_valid=1 only on the following cycle.
- Simultaneous: with count=4, one alloc and one legal free each cycle for 10 cycles -> free_count stays 4, err=0, and the freed ids reappear in FIFO order.
- Illegal free: free 3 twice after allocating it once -> the first free is accepted, the second sets err=1 and leaves free_count unchanged. err stays 1 until squash.
- Squash: squash_valid for 1 cycle mid-run at count=2, with an alloc and a free asserted that cycle -> neither takes effect, busy=1, err=0, and the list is rebuilt 0..7 in 8 cycles. A second squash at INIT cycle 4 restarts the walk, so alloc_valid rises 8 cycles after it.
